// File: rtl/uart_axil_stream_bridge_if.sv
// Bus bundle for the UART bridge: AXI4-Lite slave side, byte streams, irq.
// Ports: uart_axi_* AW/W/B/AR/R channels, tx_*/rx_* streams, uart_irq.
interface uart_axil_stream_bridge_if;
    logic [12:0] uart_axi_awaddr;
    logic        uart_axi_awvalid;
    logic        uart_axi_awready;
    logic [31:0] uart_axi_wdata;
    logic [3:0]  uart_axi_wstrb;
    logic        uart_axi_wvalid;
    logic        uart_axi_wready;
    logic [1:0]  uart_axi_bresp;
    logic        uart_axi_bvalid;
    logic        uart_axi_bready;
    logic [12:0] uart_axi_araddr;
    logic        uart_axi_arvalid;
    logic        uart_axi_arready;
    logic [31:0] uart_axi_rdata;
    logic [1:0]  uart_axi_rresp;
    logic        uart_axi_rvalid;
    logic        uart_axi_rready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        uart_irq;

    modport slave (
        input  uart_axi_awaddr, uart_axi_awvalid,
        output uart_axi_awready,
        input  uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
        output uart_axi_wready,
        output uart_axi_bresp, uart_axi_bvalid,
        input  uart_axi_bready,
        input  uart_axi_araddr, uart_axi_arvalid,
        output uart_axi_arready,
        output uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid,
        input  uart_axi_rready,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready,
        output uart_irq
    );

    modport master (
        output uart_axi_awaddr, uart_axi_awvalid,
        input  uart_axi_awready,
        output uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
        input  uart_axi_wready,
        input  uart_axi_bresp, uart_axi_bvalid,
        output uart_axi_bready,
        output uart_axi_araddr, uart_axi_arvalid,
        input  uart_axi_arready,
        input  uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid,
        output uart_axi_rready,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready,
        input  uart_irq
    );
endinterface

// File: rtl/uart_axil_stream_bridge.sv
// AXI4-Lite 16550-subset UART window at 0x1000 bridging to byte streams.
// Ports: sys_clk, sys_rst_n (async, active-low), bus (slave modport).
module uart_axil_stream_bridge #(
    parameter int FIFO_DEPTH = 16
) (
    input logic                       sys_clk,
    input logic                       sys_rst_n,
    uart_axil_stream_bridge_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [10:0] A_RBR = 11'h400;
    localparam logic [10:0] A_IER = 11'h401;
    localparam logic [10:0] A_IIR = 11'h402;
    localparam logic [10:0] A_LSR = 11'h405;
    localparam logic [10:0] A_SCR = 11'h407;

    logic [PW-1:0] rx_wptr_q, rx_wptr_d;
    logic [PW-1:0] rx_rptr_q, rx_rptr_d;
    logic [PW-1:0] tx_wptr_q, tx_wptr_d;
    logic [PW-1:0] tx_rptr_q, tx_rptr_d;
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [1:0]    ier_q, ier_d;
    logic [7:0]    scr_q, scr_d;
    logic          oe_q, oe_d;
    logic          bvalid_q, bvalid_d;
    logic          rvalid_q, rvalid_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          irq_q, irq_d;

    logic          wr_fire, rd_fire;
    logic [10:0]   wr_word, rd_word;
    logic          rx_empty, rx_full;
    logic          tx_empty, tx_full;
    logic          rx_push, rx_pop;
    logic          tx_push, tx_pop;
    logic          thr_wr;
    logic [7:0]    rx_head;
    logic [7:0]    lsr;
    logic [7:0]    iir;
    logic [7:0]    rd_byte;
    logic          unused_bits;

    assign wr_word = bus.uart_axi_awaddr[12:2];
    assign rd_word = bus.uart_axi_araddr[12:2];

    assign wr_fire = bus.uart_axi_awvalid & bus.uart_axi_wvalid & ~bvalid_q;
    assign rd_fire = bus.uart_axi_arvalid & ~rvalid_q;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);

    assign rx_head = rx_mem_q[rx_rptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a push to a full FIFO
    // still lands when it coincides with a pop.
    assign rx_pop  = rd_fire & (rd_word == A_RBR) & ~rx_empty;
    assign rx_push = bus.rx_valid & (~rx_full | rx_pop);

    assign tx_pop  = ~tx_empty & bus.tx_ready;
    assign thr_wr  = wr_fire & (wr_word == A_RBR) & bus.uart_axi_wstrb[0];
    assign tx_push = thr_wr & (~tx_full | tx_pop);

    assign lsr = {1'b0, tx_empty, tx_empty, 3'b000, oe_q, ~rx_empty};

    always_comb begin
        iir = 8'hC1;
        if (ier_q[0] && !rx_empty) begin
            iir = 8'hC4;
        end else if (ier_q[1] && tx_empty) begin
            iir = 8'hC2;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (rd_word)
            A_RBR:   rd_byte = rx_empty ? 8'h00 : rx_head;
            A_IER:   rd_byte = {6'b0, ier_q};
            A_IIR:   rd_byte = iir;
            A_LSR:   rd_byte = lsr;
            A_SCR:   rd_byte = scr_q;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        ier_d     = ier_q;
        scr_d     = scr_q;
        oe_d      = oe_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        irq_d     = (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_empty);

        if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
        if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);

        if (wr_fire && bus.uart_axi_wstrb[0]) begin
            if (wr_word == A_IER) ier_d = bus.uart_axi_wdata[1:0];
            if (wr_word == A_SCR) scr_d = bus.uart_axi_wdata[7:0];
        end

        // Clear-on-read first, so a new overrun in the same cycle wins.
        if (rd_fire && rd_word == A_LSR) oe_d = 1'b0;
        if (bus.rx_valid && rx_full && !rx_pop) oe_d = 1'b1;

        if (bvalid_q && bus.uart_axi_bready) bvalid_d = 1'b0;
        if (wr_fire) bvalid_d = 1'b1;

        if (rvalid_q && bus.uart_axi_rready) rvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_byte;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            ier_q     <= '0;
            scr_q     <= '0;
            oe_q      <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            ier_q     <= ier_d;
            scr_q     <= scr_d;
            oe_q      <= oe_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge sys_clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.uart_axi_wdata[7:0];
    end

    assign bus.uart_axi_awready = wr_fire;
    assign bus.uart_axi_wready  = wr_fire;
    assign bus.uart_axi_bresp   = 2'b00;
    assign bus.uart_axi_bvalid  = bvalid_q;
    assign bus.uart_axi_arready = ~rvalid_q;
    assign bus.uart_axi_rdata   = {24'h0, rdata_q};
    assign bus.uart_axi_rresp   = 2'b00;
    assign bus.uart_axi_rvalid  = rvalid_q;
    assign bus.tx_data          = tx_mem_q[tx_rptr_q[AW-1:0]];
    assign bus.tx_valid         = ~tx_empty;
    assign bus.rx_ready         = 1'b1;
    assign bus.uart_irq         = irq_q;

    assign unused_bits = ^{bus.uart_axi_awaddr[1:0], bus.uart_axi_araddr[1:0],
                           bus.uart_axi_wdata[31:8], bus.uart_axi_wstrb[3:1]};
endmodule

// File: tb/tb_uart_axil_stream_bridge.sv
// Scoreboard bench for uart_axil_stream_bridge with directed vectors.
// Expected read data, tx bytes and B responses are queued and popped by monitors.
module tb_uart_axil_stream_bridge;
    localparam int DEPTH = 16;
    localparam logic [12:0] RBR = 13'h1000;
    localparam logic [12:0] IER = 13'h1004;
    localparam logic [12:0] IIR = 13'h1008;
    localparam logic [12:0] LSR = 13'h1014;
    localparam logic [12:0] SCR = 13'h101C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_axil_stream_bridge_if bus ();

    uart_axil_stream_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic [1:0]  b_exp[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        total++;
        bad++;
        $display("FAIL %s: timeout or unexpected event", name);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.uart_axi_rvalid && bus.uart_axi_rready) begin
                if (rd_exp.size() == 0) fail("rdata_unexpected");
                else begin
                    check("rdata", bus.uart_axi_rdata, rd_exp.pop_front());
                    check("rresp", {30'b0, bus.uart_axi_rresp}, 32'h0);
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_exp.size() == 0) fail("tx_unexpected");
                else check("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_exp.pop_front()});
            end
            if (bus.uart_axi_bvalid && bus.uart_axi_bready) begin
                if (b_exp.size() == 0) fail("b_unexpected");
                else check("bresp", {30'b0, bus.uart_axi_bresp}, {30'b0, b_exp.pop_front()});
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(logic [12:0] a, logic [7:0] d, logic [3:0] s);
        int n;
        bus.uart_axi_awaddr = a;
        bus.uart_axi_wdata = {24'h0, d};
        bus.uart_axi_wstrb = s;
        bus.uart_axi_awvalid = 1'b1;
        bus.uart_axi_wvalid = 1'b1;
        b_exp.push_back(2'b00);
        n = 0;
        @(negedge clk);
        while (!bus.uart_axi_awready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.uart_axi_awready) fail("aw_timeout");
        @(posedge clk);
        #1;
        bus.uart_axi_awvalid = 1'b0;
        bus.uart_axi_wvalid = 1'b0;
    endtask

    task automatic axi_rd(logic [12:0] a, logic [7:0] exp);
        int n;
        rd_exp.push_back({24'h0, exp});
        bus.uart_axi_araddr = a;
        bus.uart_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.uart_axi_arready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.uart_axi_arready) fail("ar_timeout");
        @(posedge clk);
        #1;
        bus.uart_axi_arvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.uart_axi_awaddr = '0;
        bus.uart_axi_awvalid = 1'b0;
        bus.uart_axi_wdata = '0;
        bus.uart_axi_wstrb = '0;
        bus.uart_axi_wvalid = 1'b0;
        bus.uart_axi_bready = 1'b1;
        bus.uart_axi_araddr = '0;
        bus.uart_axi_arvalid = 1'b0;
        bus.uart_axi_rready = 1'b1;
        bus.tx_ready = 1'b0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        #23 rst_n = 1'b1;
        cycles(1);

        check("rst_rvalid", {31'b0, bus.uart_axi_rvalid}, 32'h0);
        check("rst_bvalid", {31'b0, bus.uart_axi_bvalid}, 32'h0);
        check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("rst_irq", {31'b0, bus.uart_irq}, 32'h0);
        check("rst_rdata", bus.uart_axi_rdata, 32'h0);
        check("rst_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
        axi_rd(LSR, 8'h60);
        axi_rd(IIR, 8'hC1);

        // THR writes held back, then drained back to back
        axi_wr(RBR, 8'h41, 4'h1);
        tx_exp.push_back(8'h41);
        axi_wr(RBR, 8'h42, 4'h1);
        tx_exp.push_back(8'h42);
        check("tx_valid_held", {31'b0, bus.tx_valid}, 32'h1);
        check("tx_head", {24'b0, bus.tx_data}, 32'h41);
        bus.tx_ready = 1'b1;
        cycles(2);
        check("tx_drained", {31'b0, bus.tx_valid}, 32'h0);

        // RX overflow by one byte
        for (int i = 0; i <= DEPTH; i++) begin
            bus.rx_data = 8'(i);
            bus.rx_valid = 1'b1;
            cycles(1);
        end
        bus.rx_valid = 1'b0;
        axi_rd(LSR, 8'h63);
        axi_rd(LSR, 8'h61);
        for (int i = 0; i < DEPTH; i++) axi_rd(RBR, 8'(i));
        axi_rd(RBR, 8'h00);
        axi_rd(LSR, 8'h60);

        // RX-data interrupt
        axi_wr(IER, 8'h01, 4'h1);
        bus.rx_data = 8'h5A;
        bus.rx_valid = 1'b1;
        cycles(1);
        bus.rx_valid = 1'b0;
        check("irq_rx_n1", {31'b0, bus.uart_irq}, 32'h0);
        cycles(1);
        check("irq_rx_n2", {31'b0, bus.uart_irq}, 32'h1);
        axi_rd(IIR, 8'hC4);
        axi_rd(RBR, 8'h5A);
        cycles(2);
        check("irq_rx_clear", {31'b0, bus.uart_irq}, 32'h0);

        // TX-empty interrupt
        axi_wr(IER, 8'h02, 4'h1);
        cycles(2);
        check("irq_thre", {31'b0, bus.uart_irq}, 32'h1);
        axi_rd(IIR, 8'hC2);
        bus.tx_ready = 1'b0;
        axi_wr(RBR, 8'h33, 4'h1);
        tx_exp.push_back(8'h33);
        cycles(2);
        check("irq_thre_drop", {31'b0, bus.uart_irq}, 32'h0);

        // Fill TX, drop one, then push on a simultaneous pop
        for (int i = 0; i < DEPTH - 1; i++) begin
            axi_wr(RBR, 8'h80 + 8'(i), 4'h1);
            tx_exp.push_back(8'h80 + 8'(i));
        end
        axi_wr(RBR, 8'hEE, 4'h1);
        cycles(1);
        bus.tx_ready = 1'b1;
        axi_wr(RBR, 8'h90, 4'h1);
        tx_exp.push_back(8'h90);
        n = 0;
        while (tx_exp.size() > 0 && n < 100) begin
            n++;
            cycles(1);
        end
        check("tx_all_emitted", tx_exp.size(), 32'h0);
        check("tx_empty_after", {31'b0, bus.tx_valid}, 32'h0);

        // Registers, aliasing and unmapped space
        axi_wr(SCR, 8'hA5, 4'h1);
        axi_rd(SCR, 8'hA5);
        axi_rd(13'h101F, 8'hA5);
        axi_rd(13'h1010, 8'h00);
        axi_wr(IER, 8'hFF, 4'h1);
        axi_rd(IER, 8'h03);
        axi_wr(IIR, 8'h00, 4'h1);
        axi_rd(IIR, 8'hC2);
        axi_wr(RBR, 8'h99, 4'h0);
        axi_wr(SCR, 8'h5C, 4'h0);
        axi_rd(SCR, 8'hA5);
        cycles(2);

        // B held off: no new AW accepted
        bus.uart_axi_bready = 1'b0;
        axi_wr(SCR, 8'h11, 4'h1);
        bus.uart_axi_awaddr = SCR;
        bus.uart_axi_wdata = 32'h22;
        bus.uart_axi_wstrb = 4'h1;
        bus.uart_axi_awvalid = 1'b1;
        bus.uart_axi_wvalid = 1'b1;
        b_exp.push_back(2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_hold_bvalid", {31'b0, bus.uart_axi_bvalid}, 32'h1);
            check("b_hold_awready", {31'b0, bus.uart_axi_awready}, 32'h0);
        end
        #1 bus.uart_axi_bready = 1'b1;
        @(negedge clk);
        check("aw_after_b", {31'b0, bus.uart_axi_awready}, 32'h1);
        @(posedge clk);
        #1;
        bus.uart_axi_awvalid = 1'b0;
        bus.uart_axi_wvalid = 1'b0;
        axi_rd(SCR, 8'h22);

        // Reset mid-transaction
        bus.tx_ready = 1'b0;
        axi_wr(RBR, 8'h77, 4'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("mid_rst_bvalid", {31'b0, bus.uart_axi_bvalid}, 32'h0);
        b_exp.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        axi_rd(LSR, 8'h60);
        axi_rd(IER, 8'h00);
        axi_rd(SCR, 8'h00);

        cycles(5);
        check("rd_queue_empty", rd_exp.size(), 32'h0);
        check("b_queue_empty", b_exp.size(), 32'h0);
        check("tx_queue_empty", tx_exp.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
